// File: rtl/cam_frame_capture.sv
// Camera capture: XCLK divider, oversampled sensor bus, pixel assembly to RAM.
// Build option: define CAM_DECIM_EN for 2:1 decimation in both axes.

module cam_frame_capture #(
   parameter int DATA_W    = 8,
   parameter int BYTES_PP  = 2,
   parameter int ADDR_W    = 17,
   parameter int FRAME_PIX = 76800,
   parameter int XCLK_DIV  = 2,
   parameter bit VS_POL    = 1'b1,
   localparam int PIX_W    = DATA_W * BYTES_PP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [DATA_W-1:0] cam_data,
   output logic              cam_xclk,
   input  logic              start,
   input  logic              cont,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic [ADDR_W:0]   pix_count
);

   localparam int XC_W = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;
   localparam int BT_W = (BYTES_PP > 1) ? $clog2(BYTES_PP) : 1;
   localparam int SR_W = (BYTES_PP > 1) ? PIX_W - DATA_W : 1;
   localparam int SY_W = DATA_W + 3;

   localparam logic [XC_W-1:0] XC_LAST = XC_W'(XCLK_DIV - 1);
   localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTES_PP - 1);
   localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W + 1)'(FRAME_PIX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_VS,
      S_CAPTURE,
      S_DONE
   } state_t;

   // ---------------- XCLK divider ----------------
   logic [XC_W-1:0] xdiv_q, xdiv_d;
   logic            xclk_q, xclk_d;

   // Count to terminal, then wrap and toggle the sensor clock.
   always_comb begin
      xdiv_d = xdiv_q + 1'b1;
      xclk_d = xclk_q;
      if (xdiv_q == XC_LAST) begin
         xdiv_d = '0;
         xclk_d = ~xclk_q;
      end
   end

   // Divider state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xdiv_q <= '0;
         xclk_q <= 1'b0;
      end else begin
         xdiv_q <= xdiv_d;
         xclk_q <= xclk_d;
      end
   end

   // ---------------- input synchroniser ----------------
   logic [SY_W-1:0] sy1_q, sy2_q;
   logic [2:0]      edg_q;

   // Two flops for metastability, then one edge register for the controls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sy1_q <= '0;
         sy2_q <= '0;
         edg_q <= '0;
      end else begin
         sy1_q <= {cam_pclk, cam_vsync, cam_href, cam_data};
         sy2_q <= sy1_q;
         edg_q <= sy2_q[SY_W-1 -: 3];
      end
   end

   logic              pclk_s, vs_s, href_s;
   logic              pclk_e, vs_e, href_e;
   logic [DATA_W-1:0] data_s;
   logic              sample, vs_act, vs_act_e;
   logic              frame_start, frame_end, href_rise;

   assign pclk_s      = sy2_q[SY_W-1];
   assign vs_s        = sy2_q[SY_W-2];
   assign href_s      = sy2_q[SY_W-3];
   assign data_s      = sy2_q[DATA_W-1:0];
   assign pclk_e      = edg_q[2];
   assign vs_e        = edg_q[1];
   assign href_e      = edg_q[0];
   assign sample      = pclk_s & ~pclk_e;
   assign vs_act      = (vs_s == VS_POL);
   assign vs_act_e    = (vs_e == VS_POL);
   assign frame_start = vs_act_e & ~vs_act;
   assign frame_end   = ~vs_act_e & vs_act;
   assign href_rise   = href_s & ~href_e;

   // ---------------- pixel assembly ----------------
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [PIX_W-1:0] shifted;
   logic             pix_keep;

   generate
      if (BYTES_PP > 1) begin : g_multi
         assign shifted = {sr_q, data_s};
      end else begin : g_single
         assign shifted = data_s;
      end
   endgenerate

`ifdef CAM_DECIM_EN
   logic line_odd_q, line_odd_d;
   logic col_odd_q, col_odd_d;
   logic href_fall;

   assign href_fall = ~href_s & href_e;
   assign pix_keep  = ~line_odd_q & ~col_odd_q;
`else
   assign pix_keep  = 1'b1;
`endif

   // ---------------- control ----------------
   state_t            state_q, state_d;
   logic              cont_q, cont_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]  wr_data_q, wr_data_d;
   logic [BT_W-1:0]   beat_q, beat_d, beat_base;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   // Next state, beat shifting, pixel writes and frame limit.
   always_comb begin
      state_d   = state_q;
      cont_d    = cont_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      sr_d      = sr_q;
      beat_base = (href_rise || !href_s) ? '0 : beat_q;
      beat_d    = beat_base;
`ifdef CAM_DECIM_EN
      line_odd_d = line_odd_q;
      col_odd_d  = col_odd_q;
      if (!href_s)
         col_odd_d = 1'b0;
      if (href_fall)
         line_odd_d = ~line_odd_q;
      if (frame_start)
         line_odd_d = 1'b0;
`endif
      if (state_q == S_CAPTURE && sample && href_s && !abort) begin
         sr_d = shifted[SR_W-1:0];
         if (beat_base == BT_LAST) begin
            beat_d = '0;
`ifdef CAM_DECIM_EN
            col_odd_d = ~col_odd_q;
`endif
            if (pix_keep) begin
               if (cnt_q == PIX_LIM) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cnt_q[ADDR_W-1:0];
                  wr_data_d = shifted;
                  cnt_d     = cnt_q + 1'b1;
               end
            end
         end else begin
            beat_d = beat_base + 1'b1;
         end
      end
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d   = S_WAIT_VS;
               cont_d    = cont;
               ovf_d     = 1'b0;
               cnt_d     = '0;
               wr_addr_d = '0;
            end
         end
         S_WAIT_VS: begin
            if (frame_start) begin
               state_d   = S_CAPTURE;
               cnt_d     = '0;
               wr_addr_d = '0;
            end
         end
         S_CAPTURE: begin
            if (frame_end)
               state_d = S_DONE;
         end
         S_DONE: begin
            state_d = cont_q ? S_WAIT_VS : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort)
         state_d = S_IDLE;
      busy_d = (state_d == S_WAIT_VS) || (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cont_q    <= 1'b0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         sr_q      <= '0;
         beat_q    <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef CAM_DECIM_EN
         line_odd_q <= 1'b0;
         col_odd_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cont_q    <= cont_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         sr_q      <= sr_d;
         beat_q    <= beat_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
`ifdef CAM_DECIM_EN
         line_odd_q <= line_odd_d;
         col_odd_q  <= col_odd_d;
`endif
      end
   end

   assign cam_xclk  = xclk_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign pix_count = cnt_q;

endmodule
